// File: rtl/mips_pipeline_pkg.sv
// Shared MIPS pipeline definitions: opcode/funct constants, sequencing FSM state and decode helpers.
package mips_pipeline_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // Wide enough for the largest legal mult/div latency (15).
  localparam int unsigned MD_CNT_W = 4;

  typedef enum logic {RUN, MD_BUSY} state_e;

  function automatic logic rt_is_src(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

  function automatic logic is_md_op(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_RTYPE) && (funct >= F_MULT) && (funct <= F_DIVU);
  endfunction

  function automatic logic is_hilo_use(input logic [5:0] op, input logic [5:0] funct);
    return is_md_op(op, funct) || ((op == OP_RTYPE) && (funct >= F_MFHI) && (funct <= F_MTLO));
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Hazard-controller signal bundle: ID/EX hazard inputs and pipeline enable/flush/bubble outputs.
interface hazard_stall_controller_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic [31:0]            ID_Instruction;
  logic                   EX_MemRead;
  logic [4:0]             EX_RegisterRt;
  logic                   EX_BranchTaken;
  logic                   PCWrite;
  logic                   IFIDWrite;
  logic                   IFIDFlush;
  logic                   IDEXBubble;
  logic                   MulDivBusy;
  logic                   MulDivDone;
  logic [STALL_CNT_W-1:0] StallCount;

  modport master (
    output ID_Instruction, EX_MemRead, EX_RegisterRt, EX_BranchTaken,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivBusy, MulDivDone, StallCount
  );

  modport slave (
    input  ID_Instruction, EX_MemRead, EX_RegisterRt, EX_BranchTaken,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivBusy, MulDivDone, StallCount
  );
endinterface

// File: rtl/muldiv_occupancy_counter.sv
// HI/LO occupancy tracker: loads the mult/div latency on issue, counts down, pulses done at expiry.
module muldiv_occupancy_counter
  import mips_pipeline_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic issue_i,
  output logic busy_o,
  output logic last_o,
  output logic done_o
);

  logic [MD_CNT_W-1:0] cnt_d, cnt_q;
  logic                done_d, done_q;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = (cnt_q == MD_CNT_W'(1));
    if (issue_i) begin
      cnt_d = MD_CNT_W'(MULDIV_LATENCY);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - MD_CNT_W'(1);
    end
  end

  // Reset clears the done flop too, so an aborted operation never reports completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign last_o = (cnt_q == MD_CNT_W'(1));
  assign done_o = done_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use and HI/LO structural stalls, taken-branch flushes,
// plus a saturating stall-cycle counter.
module hazard_stall_controller
  import mips_pipeline_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = 4,
  parameter int unsigned STALL_CNT_W    = 16
) (
  input  logic                      Clk,
  input  logic                      Rst,
  hazard_stall_controller_if.slave  bus
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt;

  assign op    = bus.ID_Instruction[31:26];
  assign rs    = bus.ID_Instruction[25:21];
  assign rt    = bus.ID_Instruction[20:16];
  assign funct = bus.ID_Instruction[5:0];

  state_e state_d, state_q;

  logic load_use, md_stall, md_issue, stall;
  logic md_busy, md_last, md_done;
  logic pc_write, ifid_write, ifid_flush, idex_bubble;

  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  assign load_use = bus.EX_MemRead && (bus.EX_RegisterRt != 5'd0) &&
                    ((bus.EX_RegisterRt == rs) || (rt_is_src(op) && (bus.EX_RegisterRt == rt)));
  assign md_stall = (state_q == MD_BUSY) && is_hilo_use(op, funct);

  // A flushed or stalled mult/div must not start occupying HI/LO.
  assign md_issue = !Rst && (state_q == RUN) && is_md_op(op, funct) && !load_use &&
                    !bus.EX_BranchTaken;

  muldiv_occupancy_counter #(
    .MULDIV_LATENCY (MULDIV_LATENCY)
  ) u_md_cnt (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .issue_i (md_issue),
    .busy_o  (md_busy),
    .last_o  (md_last),
    .done_o  (md_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (md_issue) state_d = MD_BUSY;
      MD_BUSY: if (md_last)  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall       = 1'b0;
    if (Rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (bus.EX_BranchTaken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (md_stall || load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall       = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.IFIDWrite  = ifid_write;
  assign bus.IFIDFlush  = ifid_flush;
  assign bus.IDEXBubble = idex_bubble;
  assign bus.MulDivBusy = md_busy && !Rst;
  assign bus.MulDivDone = md_done && !Rst;
  assign bus.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: per-cycle vector table plus saturation run.
module tb_hazard_stall_controller;

  localparam int unsigned LAT = 4;
  localparam int unsigned CW  = 4;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ADD  = 32'h0109_5020;
  localparam logic [31:0] ADD0 = 32'h0000_5020;
  localparam logic [31:0] ADDI = 32'h2128_0004;
  localparam logic [31:0] SW   = 32'hAD28_0000;
  localparam logic [31:0] MULT = 32'h0109_0018;
  localparam logic [31:0] MFLO = 32'h0000_5012;

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}
  localparam logic [3:0] O_RST = 4'b0011;
  localparam logic [3:0] O_RUN = 4'b1100;
  localparam logic [3:0] O_STL = 4'b0001;
  localparam logic [3:0] O_FL  = 4'b1111;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] instr;
    logic        memread;
    logic [4:0]  rt;
    logic        br;
    logic [9:0]  exp;  // {ctl[3:0], busy, done, cnt[3:0]}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_stall_controller_if #(.STALL_CNT_W(CW)) bus ();

  hazard_stall_controller #(
    .MULDIV_LATENCY (LAT),
    .STALL_CNT_W    (CW)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t v(input string name, input logic r, input logic [31:0] instr,
                             input logic mr, input logic [4:0] rt, input logic br,
                             input logic [3:0] ctl, input logic busy, input logic done,
                             input logic [3:0] cnt);
    vec_t x;
    x.name = name; x.rst = r; x.instr = instr; x.memread = mr; x.rt = rt; x.br = br;
    x.exp = {ctl, busy, done, cnt};
    return x;
  endfunction

  task automatic check_front();
    vec_t       e;
    logic [9:0] act;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty: got 0 entries, required 1");
      return;
    end
    e   = sb.pop_front();
    act = {bus.PCWrite, bus.IFIDWrite, bus.IFIDFlush, bus.IDEXBubble,
           bus.MulDivBusy, bus.MulDivDone, bus.StallCount};
    n_total++;
    if (act === e.exp) n_pass++;
    else $display("FAIL %s: got ctl=%b busy=%b done=%b cnt=%0d, required ctl=%b busy=%b done=%b cnt=%0d",
                  e.name, act[9:6], act[5], act[4], act[3:0],
                  e.exp[9:6], e.exp[5], e.exp[4], e.exp[3:0]);
  endtask

  task automatic drive(input vec_t x);
    @(posedge clk);
    #1;
    rst                = x.rst;
    bus.ID_Instruction = x.instr;
    bus.EX_MemRead     = x.memread;
    bus.EX_RegisterRt  = x.rt;
    bus.EX_BranchTaken = x.br;
    sb.push_back(x);
    @(negedge clk);
    check_front();
  endtask

  initial begin
    bus.ID_Instruction = NOP;
    bus.EX_MemRead     = 1'b0;
    bus.EX_RegisterRt  = 5'd0;
    bus.EX_BranchTaken = 1'b0;
    repeat (2) @(posedge clk);

    //                name            rst  instr mr rt  br  ctl    busy done cnt
    vecs.push_back(v("reset",         1, NOP,  0, 0,  0, O_RST, 0, 0, 0));
    vecs.push_back(v("lu_add",        0, ADD,  1, 8,  0, O_STL, 0, 0, 0));
    vecs.push_back(v("lu_release",    0, ADD,  0, 8,  0, O_RUN, 0, 0, 1));
    vecs.push_back(v("lu_zero_reg",   0, ADD0, 1, 0,  0, O_RUN, 0, 0, 1));
    vecs.push_back(v("lu_addi_dest",  0, ADDI, 1, 8,  0, O_RUN, 0, 0, 1));
    vecs.push_back(v("lu_sw_src",     0, SW,   1, 8,  0, O_STL, 0, 0, 1));
    vecs.push_back(v("lu_after_sw",   0, NOP,  0, 0,  0, O_RUN, 0, 0, 2));
    vecs.push_back(v("reset2",        1, NOP,  0, 0,  0, O_RST, 0, 0, 2));
    vecs.push_back(v("md_issue",      0, MULT, 0, 0,  0, O_RUN, 0, 0, 0));
    vecs.push_back(v("md_mflo_c4",    0, MFLO, 0, 0,  0, O_STL, 1, 0, 0));
    vecs.push_back(v("md_mflo_c3",    0, MFLO, 0, 0,  0, O_STL, 1, 0, 1));
    vecs.push_back(v("md_mflo_c2",    0, MFLO, 0, 0,  0, O_STL, 1, 0, 2));
    vecs.push_back(v("md_mflo_c1",    0, MFLO, 0, 0,  0, O_STL, 1, 0, 3));
    vecs.push_back(v("md_mflo_go",    0, MFLO, 0, 0,  0, O_RUN, 0, 1, 4));
    vecs.push_back(v("md_idle",       0, NOP,  0, 0,  0, O_RUN, 0, 0, 4));
    vecs.push_back(v("br_over_lu",    0, ADD,  1, 8,  1, O_FL,  0, 0, 4));
    vecs.push_back(v("br_after",      0, NOP,  0, 0,  0, O_RUN, 0, 0, 4));
    vecs.push_back(v("br_flush_mult", 0, MULT, 0, 0,  1, O_FL,  0, 0, 4));
    vecs.push_back(v("br_no_issue",   0, NOP,  0, 0,  0, O_RUN, 0, 0, 4));
    vecs.push_back(v("md2_issue",     0, MULT, 0, 0,  0, O_RUN, 0, 0, 4));
    vecs.push_back(v("md2_branch",    0, NOP,  0, 0,  1, O_FL,  1, 0, 4));
    vecs.push_back(v("md2_nop",       0, NOP,  0, 0,  0, O_RUN, 1, 0, 4));
    vecs.push_back(v("md2_mult_stl",  0, MULT, 0, 0,  0, O_STL, 1, 0, 4));
    vecs.push_back(v("md2_no_reload", 0, NOP,  0, 0,  0, O_RUN, 1, 0, 5));
    vecs.push_back(v("md2_done",      0, NOP,  0, 0,  0, O_RUN, 0, 1, 5));
    vecs.push_back(v("md2_idle",      0, NOP,  0, 0,  0, O_RUN, 0, 0, 5));
    vecs.push_back(v("rm_issue",      0, MULT, 0, 0,  0, O_RUN, 0, 0, 5));
    vecs.push_back(v("rm_c4",         0, NOP,  0, 0,  0, O_RUN, 1, 0, 5));
    vecs.push_back(v("rm_c3",         0, NOP,  0, 0,  0, O_RUN, 1, 0, 5));
    vecs.push_back(v("rm_reset_c2",   1, NOP,  0, 0,  0, O_RST, 0, 0, 5));
    vecs.push_back(v("rm_cleared",    0, NOP,  0, 0,  0, O_RUN, 0, 0, 0));
    vecs.push_back(v("rm_no_done",    0, NOP,  0, 0,  0, O_RUN, 0, 0, 0));
    vecs.push_back(v("rm_mflo_run",   0, MFLO, 0, 0,  0, O_RUN, 0, 0, 0));

    foreach (vecs[i]) drive(vecs[i]);

    // Back-to-back load-use stalls must saturate the narrow counter.
    drive(v("sat_reset", 1, NOP, 0, 0, 0, O_RST, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      drive(v($sformatf("sat_stall_%0d", i), 0, ADD, 1, 9, 0, O_STL, 0, 0,
              (i > 15) ? 4'd15 : 4'(i)));
    end
    drive(v("sat_hold", 0, NOP, 0, 0, 0, O_RUN, 0, 0, 15));

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
